adder_seq: RTL and testbench
============================

ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK ≥ 1.
REQ-003 The port list SHALL be, one port per line, in this order: clock and reset first, then handshake, operand and result ports (REQ-004 to REQ-013).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request an addition; sampled only in IDLE or DONE.
REQ-007 a  input  WIDTH  operand A; captured on an accepted start.
REQ-008 b  input  WIDTH  operand B; captured on an accepted start.
REQ-009 cin  input  1  carry-in to bit 0; captured on an accepted start.
REQ-010 s  output  WIDTH  registered sum.
REQ-011 cout  output  1  registered carry-out of bit WIDTH-1.
REQ-012 busy  output  1  high while in BUSY.
REQ-013 done  output  1  one-cycle pulse; s and cout are valid and new.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-015 IDLE with start=1: capture a, b and cin; clear chunk counter k; go to BUSY. IDLE with start=0: stay in IDLE.
REQ-016 BUSY, per edge: add a[k*CHUNK +: CHUNK], b[k*CHUNK +: CHUNK] and the carry register; store the chunk sum into a working register; update the carry register; increment k.
REQ-017 BUSY with k = NCHUNK-1: after processing that chunk, copy the working register to s, copy the final carry to cout, and go to DONE.
REQ-018 Latency: start accepted at edge E0; done=1 in the cycle after edge E0+NCHUNK. With the defaults, done rises 4 edges after the accepting edge.
REQ-019 DONE: done=1 for exactly one cycle. With start=1, accept the new operands and go to BUSY (back-to-back operation); otherwise go to IDLE.
REQ-020 start is ignored while in BUSY; the captured operands are unaffected by changes on a, b and cin during BUSY.
REQ-021 s and cout SHALL change only on the transition into DONE, or on reset; they hold their value otherwise.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; {cout,s} = a + b + cin exactly.
REQ-023 busy=1 iff state=BUSY; done=1 iff state=DONE.

Reset
REQ-024 When rst=1 at an edge: state=IDLE; s=0; cout=0; busy=0; done=0; k=0; carry register=0.
REQ-025 rst asserted mid-operation SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
REQ-026 Macro ADDER_SEQ_SUB_EN, when defined, SHALL add input port sub (1 bit), placed after cin.
REQ-027 With ADDER_SEQ_SUB_EN, sub is captured on an accepted start. When the captured sub=1, the block uses ~b as operand B and forces the carry-in to 1, ignoring cin. It then produces s = a - b mod 2^WIDTH, with cout=1 iff a ≥ b.
REQ-028 Without ADDER_SEQ_SUB_EN, the sub port does not exist and the block is add-only.

Structure
REQ-029 Package adder_pkg SHALL hold the state enum type (IDLE/BUSY/DONE) and the default values of WIDTH and CHUNK.
REQ-030 Sub-module adder_nbit SHALL be a purely combinational CHUNK-bit ripple-carry adder (a, b, cin -> s, cout), instantiated once.

Verification (WIDTH=16, CHUNK=4)
REQ-031 After reset, a=0x0000, b=0x0000, cin=0, start pulse -> done exactly 4 edges after acceptance; s=0x0000, cout=0; no X/Z on any output.
REQ-032 a=0xFFFF, b=0x0000, cin=1 (full carry propagation through all chunks) -> s=0x0000, cout=1.
REQ-033 a=0x1234, b=0x4321, cin=0, then in the DONE cycle start with a=0x8000, b=0x8000 -> first s=0x5555, cout=0; second s=0x0000, cout=1, done 4 edges later.
REQ-034 start re-pulsed and a, b changed during BUSY -> result is from the originally captured operands; a single done pulse.
REQ-035 rst asserted 2 cycles into BUSY -> no done pulse; s=0, cout=0, busy=0 on the next cycle.
REQ-036 With ADDER_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0; sub=1, a=0x0007, b=0x0005 -> s=0x0002, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;

endpackage

// File: rtl/adder_nbit.sv
// Combinational W-bit ripple-carry adder used as the per-cycle chunk slice.
module adder_nbit
  import adder_pkg::*;
#(
  parameter int W = CHUNK_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_seq.sv
// Sequential WIDTH-bit adder processing CHUNK bits per clock.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
    $error("adder_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  state_t           state_nxt;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] wrk;
  logic [WIDTH-1:0] wrk_nxt;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             accept;
  logic             last;

  // Subtraction is folded into capture: a - b = a + ~b + 1.
`ifdef ADDER_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == BUSY) && (k == KLAST);

  always_comb begin
    chunk_a = a_r[int'(k) * CHUNK +: CHUNK];
    chunk_b = b_r[int'(k) * CHUNK +: CHUNK];
  end

  adder_nbit #(
    .W (CHUNK)
  ) u_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  always_comb begin
    wrk_nxt = wrk;
    wrk_nxt[int'(k) * CHUNK +: CHUNK] = chunk_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? BUSY : IDLE;
      BUSY:    state_nxt = last  ? DONE : BUSY;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // Control and result registers; s/cout only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      carry <= c_in;
    end else if (state == BUSY) begin
      k     <= k + 1'b1;
      carry <= chunk_c;
      if (last) begin
        s    <= wrk_nxt;
        cout <= chunk_c;
      end
    end
  end

  // Operand and working registers carry no reset; they are qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b_in;
    end
    if (state == BUSY) wrk <= wrk_nxt;
  end

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq (WIDTH=16, CHUNK=4).
module tb_adder_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ADDER_SEQ_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W:0] sb_q[$];

  adder_seq #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDER_SEQ_SUB_EN
    .sub   (sub),
`endif
    .s     (s),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Drives one operation, pushes the model result, then checks latency and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic tsub, input string name);
    int lat;
    logic [W:0] exp;
    a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
    sub = tsub;
`endif
    if (tsub) exp = {1'b0, ta} + {1'b0, ~tb_} + 17'd1;
    else      exp = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
    sb_q.push_back(exp);
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy after accept: got %b want 1", name, busy);
    end
    wait_done(lat);
    tests_run++;
    if (lat != 4) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    exp = sb_q.pop_front();
    tests_run++;
    if ({cout, s} !== exp) begin
      tests_failed++;
      $display("FAIL %s result: got cout=%b s=%h want cout=%b s=%h",
               name, cout, s, exp[W], exp[W-1:0]);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done width: got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({s, cout, busy, done} !== {16'h0000, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset outputs: got s=%h cout=%b busy=%b done=%b want 0", s, cout, busy, done);
    end
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_carry_chain();
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "carry_chain");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "all_ones");
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "mid_carry");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W:0] exp;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    sb_q.push_back(17'h05555);
    tick();
    start = 1'b0;
    wait_done(lat);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    sb_q.push_back(17'h10000);
    exp = sb_q.pop_front();
    tests_run++;
    if (lat != 4 || {cout, s} !== exp) begin
      tests_failed++;
      $display("FAIL b2b first: got lat=%0d cout=%b s=%h want lat=4 cout=%b s=%h",
               lat, cout, s, exp[W], exp[W-1:0]);
    end
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b reaccept: got busy=%b want 1", busy);
    end
    wait_done(lat);
    exp = sb_q.pop_front();
    tests_run++;
    if (lat != 4 || {cout, s} !== exp) begin
      tests_failed++;
      $display("FAIL b2b second: got lat=%0d cout=%b s=%h want lat=4 cout=%b s=%h",
               lat, cout, s, exp[W], exp[W-1:0]);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [W:0] exp;
    logic [W:0] got;
    a = 16'h0ABC; b = 16'h1357; cin = 1'b1; start = 1'b1;
    sb_q.push_back(17'h01E14);
    tick();
    got = '0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      start = (i < 3);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      if (done === 1'b1) begin
        pulses++;
        got = {cout, s};
      end
      tick();
    end
    start = 1'b0;
    exp = sb_q.pop_front();
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL busy_ignore pulses: got %0d want 1", pulses);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL busy_ignore result: got %h want %h", got, exp);
    end
  endtask

  task automatic test_abort();
    int pulses;
    run_op(16'h7777, 16'h1111, 1'b0, 1'b0, "pre_abort");
    a = 16'h2222; b = 16'h3333; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({s, cout, busy, done} !== {16'h0000, 3'b000}) begin
      tests_failed++;
      $display("FAIL abort outputs: got s=%h cout=%b busy=%b done=%b want 0", s, cout, busy, done);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    tests_run++;
    if (pulses != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort quiet: got pulses=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random");
    end
  endtask

`ifdef ADDER_SEQ_SUB_EN
  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_pos");
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, "sub_eq");
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_random();
`ifdef ADDER_SEQ_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
